ps2_scan_fifo_rx: RTL

//  Parametrised PS/2 keyboard receiver. Replaces the single-byte receiver/break filter: adds a ps2c

---
 rtl/ps2_scan_fifo_rx_if.sv | 31 +++
 rtl/ps2_scan_fifo_rx.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_scan_fifo_rx_if.sv
// Bus bundle for the PS/2 scan-code receiver: line inputs, enable/pop controls and FIFO head/status.
// The FIFO_DEPTH parameter here must match the one given to ps2_scan_fifo_rx.
interface ps2_scan_fifo_rx_if #(
  parameter int unsigned FIFO_DEPTH = 8
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic          en;
  logic          ps2d;
  logic          ps2c;
  logic          rd;
  logic          valid;
  logic [7:0]    key_code;
  logic          key_ext;
  logic          key_brk;
  logic          full;
  logic [CW-1:0] count;
  logic          parity_err;
  logic          frame_err;
  logic          overflow;

  modport master (
    output en, ps2d, ps2c, rd,
    input  valid, key_code, key_ext, key_brk, full, count, parity_err, frame_err, overflow
  );

  modport slave (
    input  en, ps2d, ps2c, rd,
    output valid, key_code, key_ext, key_brk, full, count, parity_err, frame_err, overflow
  );
endinterface

// File: rtl/ps2_scan_fifo_rx.sv
// PS/2 keyboard receiver: filtered clock, framed byte capture with parity/stop/timeout checks,
// E0/F0 prefix decode and a show-ahead key-event FIFO.
module ps2_scan_fifo_rx #(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter int unsigned BREAK_MODE  = 0
) (
  input logic              clk,
  input logic              rst,
  ps2_scan_fifo_rx_if.slave bus
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAR, S_STOP} state_t;

  // Synchronisers and clock glitch filter
  logic                  c_s1_q, c_s2_q, d_s1_q, d_s2_q;
  logic [FILTER_LEN-1:0] flt_q, flt_d;
  logic                  lvl_q, lvl_d, fall_q;

  always_comb begin
    flt_d = {flt_q[FILTER_LEN-2:0], c_s2_q};
    lvl_d = lvl_q;
    if (&flt_d)       lvl_d = 1'b1;
    else if (~|flt_d) lvl_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      c_s1_q <= 1'b1;
      c_s2_q <= 1'b1;
      d_s1_q <= 1'b1;
      d_s2_q <= 1'b1;
      flt_q  <= '1;
      lvl_q  <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      c_s1_q <= bus.ps2c;
      c_s2_q <= c_s1_q;
      d_s1_q <= bus.ps2d;
      d_s2_q <= d_s1_q;
      flt_q  <= flt_d;
      lvl_q  <= lvl_d;
      fall_q <= lvl_q & ~lvl_d;
    end
  end

  // Frame FSM with timeout; clr_pfx_q marks errors that must wipe the prefix flags
  state_t        st_q;
  logic [2:0]    bit_q;
  logic [7:0]    sh_q;
  logic          par_q;
  logic [TW-1:0] tmo_q;
  logic          byte_rdy_q, perr_q, ferr_q, clr_pfx_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      st_q       <= S_IDLE;
      bit_q      <= '0;
      sh_q       <= '0;
      par_q      <= 1'b0;
      tmo_q      <= '0;
      byte_rdy_q <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      clr_pfx_q  <= 1'b0;
    end else begin
      byte_rdy_q <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      clr_pfx_q  <= 1'b0;
      if (!bus.en) begin
        st_q  <= S_IDLE;
        tmo_q <= '0;
      end else if (st_q == S_IDLE) begin
        tmo_q <= '0;
        if (fall_q && !d_s2_q) begin
          st_q  <= S_DATA;
          bit_q <= '0;
        end
      end else if (fall_q) begin
        tmo_q <= '0;
        case (st_q)
          S_DATA: begin
            sh_q  <= {d_s2_q, sh_q[7:1]};
            bit_q <= bit_q + 3'd1;
            if (bit_q == 3'd7) st_q <= S_PAR;
          end
          S_PAR: begin
            par_q <= d_s2_q;
            st_q  <= S_STOP;
          end
          default: begin
            st_q <= S_IDLE;
            if (!(^{sh_q, par_q})) begin
              perr_q    <= 1'b1;
              clr_pfx_q <= 1'b1;
            end else if (!d_s2_q) begin
              ferr_q    <= 1'b1;
              clr_pfx_q <= 1'b1;
            end else begin
              byte_rdy_q <= 1'b1;
            end
          end
        endcase
      end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
        ferr_q <= 1'b1;
        st_q   <= S_IDLE;
        tmo_q  <= '0;
      end else begin
        tmo_q <= tmo_q + TW'(1);
      end
    end
  end

  // Prefix decoder and FIFO control
  logic          ext_q, ext_d, brk_q, brk_d;
  logic          evt_c, pop_c, push_c, ovf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic          valid_q, full_q, ovf_q;
  logic [9:0]    mem_q [FIFO_DEPTH];

  always_comb begin
    ext_d = ext_q;
    brk_d = brk_q;
    evt_c = 1'b0;
    if (clr_pfx_q) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_rdy_q) begin
      if (sh_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (sh_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        evt_c = brk_q ? (BREAK_MODE != 0) : 1'b1;
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
    pop_c  = bus.rd & valid_q;
    push_c = evt_c & (~full_q | pop_c);
    ovf_d  = evt_c & full_q & ~pop_c;
    cnt_d  = cnt_q + CW'(push_c) - CW'(pop_c);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
    end else begin
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      cnt_q   <= cnt_d;
      valid_q <= (cnt_d != '0);
      full_q  <= (cnt_d == CW'(FIFO_DEPTH));
      ovf_q   <= ovf_d;
      if (push_c) begin
        mem_q[wr_ptr_q] <= {ext_q, brk_q, sh_q};
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_c) rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  assign bus.valid      = valid_q;
  assign bus.key_code   = mem_q[rd_ptr_q][7:0];
  assign bus.key_brk    = mem_q[rd_ptr_q][8];
  assign bus.key_ext    = mem_q[rd_ptr_q][9];
  assign bus.full       = full_q;
  assign bus.count      = cnt_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overflow   = ovf_q;
endmodule
